gf180mcu_fd_sc_mcu9t5v0__clkmon: RTL
====================================

Name: gf180mcu_fd_sc_mcu9t5v0__clkmon

Overview:
Clock-activity monitor that sits at the receiving end of a clock-tree branch driven by clkinv/clkbuf cells. It treats the monitored clock MCLK as an asynchronous data input and synchronizes it into the CLK domain. It counts MCLK rising edges over a programmable window of CLK cycles and reports the count plus stuck, slow and fast flags. It is used for clock-health supervision in mcu9t5v0 designs.

Parameters:
CNT_W, 6, width of the edge counter, CNT, LO_TH and HI_TH
WIN_W, 8, width of the WIN window-length input
SYNC_STAGES, 2, number of MCLK synchronizer flops (legal range 2..4)

Ports:
CLK  input  1  monitor clock; all state updates on the rising edge
RN  input  1  reset; asynchronous assert, active-low
EN  input  1  monitor enable; level-sensitive
MCLK  input  1  monitored clock; asynchronous to CLK
WIN  input  WIN_W  window length is WIN+1 CLK cycles; sampled at window start
LO_TH  input  CNT_W  slow threshold
HI_TH  input  CNT_W  fast threshold
CNT  output  CNT_W  edge count of the last completed window
VALID  output  1  one-cycle pulse when CNT and the flags update
STUCK  output  1  last window saw zero MCLK edges
SLOW  output  1  last window count was less than LO_TH
FAST  output  1  last window count was greater than HI_TH

Behaviour:
- Reset (RN=0, asynchronous):
  - State goes to IDLE.
  - Synchronizer, edge-detect register, window counter and edge counter clear to 0.
  - CNT=0, VALID=0, STUCK=0, SLOW=0, FAST=0.
- Synchronizer: SYNC_STAGES flops in series. The edge-detect register holds the previous synchronized value.
- Rising edge: synchronized value is 1 and the previous value is 0. The edge is seen SYNC_STAGES+1 CLK cycles after MCLK rises.
- FSM states: IDLE, ARM, COUNT.
  - IDLE: counters are held at 0. EN=1 moves to ARM.
  - ARM: lasts exactly SYNC_STAGES cycles while the synchronizer fills. The edge-detect register loads the synchronized value every cycle, so no edge is counted during ARM. The last ARM cycle loads the window counter with WIN and clears the edge counter. Next state is COUNT.
  - COUNT: the window counter decrements each cycle. Each detected edge increments the edge counter; the counter saturates at 2^CNT_W-1 and does not wrap.
- Terminal cycle (window counter = 0, in COUNT):
  - An edge detected in the terminal cycle is included in the count.
  - The next cycle registers CNT = final count and pulses VALID=1 for one cycle.
  - STUCK = (count==0); SLOW = (count<LO_TH); FAST = (count>HI_TH). Comparisons are unsigned.
  - In the same terminal cycle the window counter reloads from the current WIN and the edge counter clears. The next window starts back-to-back, with no dead cycle and no missed edge.
- Flags:
  - STUCK and SLOW can both be 1.
  - If LO_TH > HI_TH, SLOW and FAST can both be 1. This is legal and not checked.
- Between VALID pulses, CNT and the flags hold their values.
- EN deasserted in any state: next state is IDLE and the window in progress is abandoned with no VALID pulse. CNT holds its value; STUCK, SLOW and FAST clear (this is the non-sticky behaviour).
- EN reasserted: the FSM passes through ARM again.
- WIN, LO_TH and HI_TH changes mid-window:
  - WIN takes effect at the next reload.
  - LO_TH and HI_TH are sampled in the terminal cycle.
- Accuracy: a count is exact only if MCLK high and low phases are each at least 2 CLK periods. Faster MCLK aliases; this is documented and not detected.
- Latency from EN rise to the first VALID: 1 (IDLE) + SYNC_STAGES + (WIN+1) + 1 cycles.

Optional Feature:
Macro: GF180MCU_CLKMON_STICKY_EN.
- Defined:
  - STUCK, SLOW and FAST are sticky. Once set by any window they remain 1 across later windows.
  - They clear only on RN=0 or when EN=0.
  - CNT still updates every window.
- Undefined: each VALID pulse overwrites all three flags with the current window's result.

Test Plan:
1. Reset mid-count: RN pulsed low at an arbitrary point during COUNT -> every output returns to 0 immediately, with no dependence on CLK. After release, the FSM stays in IDLE until EN=1.
2. Nominal count: WIN=15, MCLK period 4 CLK cycles, LO_TH=3, HI_TH=5 -> VALID pulses every 16 cycles, CNT=4, STUCK=SLOW=FAST=0. Back-to-back windows give a steady CNT=4.
3. Stuck clock: MCLK held at 1 from EN rise, WIN=7 -> first VALID has CNT=0, STUCK=1 and SLOW=1 (LO_TH=1). No edge is counted during ARM.
4. Saturation and fast flag: CNT_W=3, WIN=63, MCLK period 4 -> CNT=7 (saturated, not wrapped) and FAST=1 with HI_TH=5.
5. EN drop mid-window: EN=0 at window cycle 5 -> no VALID, flags clear, CNT holds its previous value. EN=1 again -> the first VALID arrives exactly 1+SYNC_STAGES+WIN+2 cycles later.
6. Sticky option: GF180MCU_CLKMON_STICKY_EN defined, one stuck window then healthy windows -> STUCK stays 1 while CNT shows the healthy count. With the macro undefined, STUCK returns to 0 on the next VALID.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkmon.sv
// Clock-activity monitor: counts synchronized MCLK rising edges over WIN+1 CLK cycles.
// Define GF180MCU_CLKMON_STICKY_EN to make STUCK/SLOW/FAST sticky until EN=0 or reset.
module gf180mcu_fd_sc_mcu9t5v0__clkmon #(
  parameter int CNT_W       = 6,
  parameter int WIN_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             MCLK,
  input  logic [WIN_W-1:0] WIN,
  input  logic [CNT_W-1:0] LO_TH,
  input  logic [CNT_W-1:0] HI_TH,
  output logic [CNT_W-1:0] CNT,
  output logic             VALID,
  output logic             STUCK,
  output logic             SLOW,
  output logic             FAST
);

  typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

  localparam logic [2:0]       ARM_LAST = 3'(SYNC_STAGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

  state_t           state;
  state_t           next_state;
  logic [SYNC_STAGES-1:0] sync;
  logic             prev;
  logic [2:0]       arm_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] final_cnt;
  logic             synced;
  logic             edge_seen;
  logic             arm_last;
  logic             counting;
  logic             terminal;
  logic             is_zero;
  logic             is_slow;
  logic             is_fast;

  assign synced    = sync[SYNC_STAGES-1];
  assign edge_seen = synced & ~prev;
  // Edge in the terminal cycle still counts; saturate instead of wrapping.
  assign final_cnt = (edge_seen && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_ONE : edge_cnt;
  assign is_zero   = (final_cnt == '0);
  assign is_slow   = (final_cnt < LO_TH);
  assign is_fast   = (final_cnt > HI_TH);

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = ARM;
      ARM:     if (arm_last) next_state = COUNT;
      COUNT:   next_state = COUNT;
      default: next_state = IDLE;
    endcase
    if (!EN) next_state = IDLE;
  end

  always_comb begin
    arm_last = 1'b0;
    counting = 1'b0;
    terminal = 1'b0;
    if (EN) begin
      case (state)
        ARM: arm_last = (arm_cnt == ARM_LAST);
        COUNT: begin
          counting = 1'b1;
          terminal = (win_cnt == '0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync     <= '0;
      prev     <= 1'b0;
      arm_cnt  <= '0;
      win_cnt  <= '0;
      edge_cnt <= '0;
      CNT      <= '0;
      VALID    <= 1'b0;
      STUCK    <= 1'b0;
      SLOW     <= 1'b0;
      FAST     <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], MCLK};
      prev    <= synced;
      arm_cnt <= (EN && state == ARM && !arm_last) ? arm_cnt + 3'd1 : 3'd0;
      VALID   <= terminal;

      if (arm_last || terminal) begin
        win_cnt  <= WIN;
        edge_cnt <= '0;
      end else if (counting) begin
        win_cnt  <= win_cnt - WIN_ONE;
        edge_cnt <= final_cnt;
      end else begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end

      // CNT survives an abandoned window; the flags do not.
      if (!EN) begin
        STUCK <= 1'b0;
        SLOW  <= 1'b0;
        FAST  <= 1'b0;
      end else if (terminal) begin
        CNT <= final_cnt;
`ifdef GF180MCU_CLKMON_STICKY_EN
        STUCK <= STUCK | is_zero;
        SLOW  <= SLOW  | is_slow;
        FAST  <= FAST  | is_fast;
`else
        STUCK <= is_zero;
        SLOW  <= is_slow;
        FAST  <= is_fast;
`endif
      end
    end
  end

endmodule
